// File: rtl/ram_disp_pkg.sv
// Shared types and constants for the RAM address/data seven-segment display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package ram_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_D = 2'd2,
        LOAD   = 2'd3
    } conv_state_e;

    localparam int DIGIT_NUM = 6;

    localparam logic [7:0] SEG_0       = 8'hC0;
    localparam logic [7:0] SEG_1       = 8'hF9;
    localparam logic [7:0] SEG_2       = 8'hA4;
    localparam logic [7:0] SEG_3       = 8'hB0;
    localparam logic [7:0] SEG_4       = 8'h99;
    localparam logic [7:0] SEG_5       = 8'h92;
    localparam logic [7:0] SEG_6       = 8'h82;
    localparam logic [7:0] SEG_7       = 8'hF8;
    localparam logic [7:0] SEG_8       = 8'h80;
    localparam logic [7:0] SEG_9       = 8'h90;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], bit_in};
    endfunction

endpackage

// File: rtl/ram_disp_ctrl_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter, one shift per clock.
// The start edge performs the first shift, so a conversion occupies exactly 8 edges.
module bin2bcd_8
    import ram_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  sh_q, sh_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        active_q, active_d;

    always_comb begin
        sh_d     = sh_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            bcd_d    = dabble_step(12'd0, bin[7]);
            sh_d     = {bin[6:0], 1'b0};
            cnt_d    = 3'd1;
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d = dabble_step(bcd_q, sh_q[7]);
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // High during the cycle whose closing edge performs the eighth shift.
    assign done = active_q && (cnt_q == 3'd7);
    assign bcd  = bcd_q;

endmodule

// File: rtl/ram_disp_ctrl.sv
// RAM address/data viewer: converts captured address and data to BCD and scans a
// 6-digit seven-segment display. Define ZERO_BLANK_EN for leading-zero blanking per field.
module ram_disp_ctrl
    import ram_disp_pkg::*;
#(
    parameter logic [15:0] CNT_SCAN = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       upd_en,
    output logic       busy,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    conv_state_e state_q, state_d;
    logic [7:0]  cap_addr_q, cap_addr_d;
    logic [7:0]  cap_data_q, cap_data_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        start_q, start_d;
    logic [11:0] addr_bcd_q, addr_bcd_d;
    logic [23:0] disp_q, disp_d;

    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [7:0]  conv_bin;

    assign conv_bin = (state_q == CONV_D) ? cap_data_q : cap_addr_q;
    assign busy     = (state_q != IDLE);

    bin2bcd_8 u_bin2bcd (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (start_q),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        start_d     = 1'b0;
        addr_bcd_d  = addr_bcd_q;
        disp_d      = disp_q;

        // Strobes arriving while busy are parked; only the newest survives.
        if (upd_en && (state_q != IDLE)) begin
            pend_d      = 1'b1;
            pend_addr_d = addr_in;
            pend_data_d = data_in;
        end

        case (state_q)
            IDLE: begin
                if (upd_en) begin
                    cap_addr_d = addr_in;
                    cap_data_d = data_in;
                    start_d    = 1'b1;
                    state_d    = CONV_A;
                end
            end
            CONV_A: begin
                if (conv_done) begin
                    start_d = 1'b1;
                    state_d = CONV_D;
                end
            end
            CONV_D: begin
                if (start_q) begin
                    addr_bcd_d = conv_bcd;
                end
                if (conv_done) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d = {addr_bcd_q, conv_bcd};
                if (upd_en) begin
                    cap_addr_d = addr_in;
                    cap_data_d = data_in;
                    pend_d     = 1'b0;
                    start_d    = 1'b1;
                    state_d    = CONV_A;
                end else if (pend_q) begin
                    cap_addr_d = pend_addr_q;
                    cap_data_d = pend_data_q;
                    pend_d     = 1'b0;
                    start_d    = 1'b1;
                    state_d    = CONV_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            start_q     <= 1'b0;
            addr_bcd_q  <= '0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            start_q     <= start_d;
            addr_bcd_q  <= addr_bcd_d;
            disp_q      <= disp_d;
        end
    end

    // Per-digit segment code; digit gi sits in disp_q[gi*4 +: 4], idx0 = data ones.
    logic [7:0] digit_seg [DIGIT_NUM];

    generate
        for (genvar gi = 0; gi < DIGIT_NUM; gi++) begin : g_digit
            logic       blank;
            logic [7:0] code;
`ifdef ZERO_BLANK_EN
            if (gi % 3 == 2) begin : g_hund
                assign blank = (disp_q[gi*4 +: 4] == 4'd0);
            end else if (gi % 3 == 1) begin : g_tens
                assign blank = (disp_q[(gi+1)*4 +: 4] == 4'd0) && (disp_q[gi*4 +: 4] == 4'd0);
            end else begin : g_ones
                assign blank = 1'b0;
            end
`else
            assign blank = 1'b0;
`endif
            assign code = blank ? SEG_BLANK : seg_encode(disp_q[gi*4 +: 4]);
            if (gi == 3) begin : g_dp
                assign digit_seg[gi] = code & SEG_DP_MASK;
            end else begin : g_nodp
                assign digit_seg[gi] = code;
            end
        end
    endgenerate

    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;
    logic        wrap;
    logic [7:0]  cur_seg;

    assign wrap = (scan_cnt_q == CNT_SCAN);

    always_comb begin
        cur_seg = SEG_BLANK;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (idx_q == i[2:0]) begin
                cur_seg = digit_seg[i];
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        idx_d      = idx_q;
        sel_d      = sel_q;
        seg_d      = seg_q;
        // Outputs latch the current index at the wrap, so new digit values wait for it.
        if (wrap) begin
            scan_cnt_d = '0;
            sel_d      = ~(6'd1 << idx_q);
            seg_d      = cur_seg;
            idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= 6'h3F;
            seg_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_ram_disp_ctrl.sv
// Directed bench for ram_disp_ctrl with a short scan dwell; expected segment codes
// come from the hand-written digit table below (honours ZERO_BLANK_EN when defined).
module tb_ram_disp_ctrl;

    localparam logic [15:0] CNT_SCAN = 16'd9;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] addr_in   = 8'd0;
    logic [7:0] data_in   = 8'd0;
    logic       upd_en    = 1'b0;
    logic       busy;
    logic [5:0] sel;
    logic [7:0] seg;

    int errors = 0;
    int checks = 0;
    bit mon_en    = 1'b0;
    bit saw_stale = 1'b0;

    always #5 sys_clk = ~sys_clk;

    ram_disp_ctrl #(.CNT_SCAN(CNT_SCAN)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .upd_en    (upd_en),
        .busy      (busy),
        .sel       (sel),
        .seg       (seg)
    );

    // 001/002 must never reach the display: data ones '2' or address ones '1' with dp.
    always @(negedge sys_clk) begin
        if (mon_en && ((sel == 6'b111110 && seg == 8'hA4) || (sel == 6'b110111 && seg == 8'h79))) begin
            saw_stale = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int digit);
        case (digit)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input int a, input int d);
        int val, pos, digit;
        logic [7:0] code;
        val   = (idx < 3) ? d : a;
        pos   = idx % 3;
        digit = (pos == 0) ? val % 10 : (pos == 1) ? (val / 10) % 10 : val / 100;
        code  = seg_of(digit);
`ifdef ZERO_BLANK_EN
        if (pos == 2 && val < 100) code = 8'hFF;
        if (pos == 1 && val < 10)  code = 8'hFF;
`endif
        if (idx == 3) code = code & 8'h7F;
        return code;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [7:0] d);
        addr_in = a;
        data_in = d;
        upd_en  = 1'b1;
        tick();
        upd_en  = 1'b0;
    endtask

    // Waits for a fresh selection of digit idx so the captured seg reflects current registers.
    task automatic read_digit(input int idx, output logic [7:0] s, output bit ok);
        logic [5:0] target;
        int n;
        target = ~(6'd1 << idx);
        ok = 1'b0;
        s  = 8'h00;
        n  = 0;
        while (sel == target && n < 100) begin tick(); n++; end
        n = 0;
        while (sel != target && n < 100) begin tick(); n++; end
        if (sel == target) begin
            ok = 1'b1;
            s  = seg;
        end
    endtask

    task automatic check_disp(input string tag, input int a, input int d);
        logic [7:0] s;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            read_digit(i, s, ok);
            if (!ok) check($sformatf("%s_idx%0d_timeout", tag, i), 32'(ok), 32'd1);
            else     check($sformatf("%s_idx%0d", tag, i), 32'(s), 32'(exp_seg(i, a, d)));
        end
        $display("txn %s: addr=%0d data=%0d display checked", tag, a, d);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit blank_ok;
        int na [3];
        int nd [3];
        na = '{0, 128, 99};
        nd = '{0, 255, 100};

        repeat (3) tick();
        check("rst_sel", 32'(sel), 32'h3F);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        sys_rst_n = 1'b1;

        blank_ok = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (sel !== 6'h3F || seg !== 8'hFF) blank_ok = 1'b0;
        end
        check("blank_dwell", 32'(blank_ok), 32'd1);
        tick();
        check("first_sel", 32'(sel), 32'h3E);
        check("first_seg", 32'(seg), 32'hC0);
        repeat (9) tick();
        check("dwell_sel", 32'(sel), 32'h3E);
        tick();
        check("idx1_sel", 32'(sel), 32'h3D);
        check_disp("zero", 0, 0);
        $display("txn reset_scan: blank dwell and first digits checked");

        // Single update: 255 / 7
        check("busy_pre", 32'(busy), 32'd0);
        strobe(8'd255, 8'd7);
        check("busy_n1", 32'(busy), 32'd1);
        repeat (16) tick();
        check("busy_n17", 32'(busy), 32'd1);
        tick();
        check("busy_n18", 32'(busy), 32'd0);
        check_disp("a255_d7", 255, 7);

        // Back-to-back strobes: only the latest pending value survives
        mon_en = 1'b1;
        strobe(8'd10, 8'd99);
        repeat (4) tick();
        strobe(8'd1, 8'd2);
        check("busy_pend1", 32'(busy), 32'd1);
        repeat (3) tick();
        strobe(8'd3, 8'd4);
        repeat (7) tick();
        check("busy_n16_pipe", 32'(busy), 32'd1);
        tick();
        check("busy_n17_pipe", 32'(busy), 32'd1);
        repeat (16) tick();
        check("busy_n33_pipe", 32'(busy), 32'd1);
        tick();
        check("busy_n34_pipe", 32'(busy), 32'd0);
        check_disp("a3_d4", 3, 4);
        mon_en = 1'b0;
        check("stale_shown", 32'(saw_stale), 32'd0);

        // Reset in the middle of a conversion
        strobe(8'd200, 8'd128);
        repeat (10) tick();
        check("busy_mid", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 32'h3F);
        check("arst_seg", 32'(seg), 32'hFF);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        check_disp("post_rst", 0, 0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Boundary values
        for (int k = 0; k < 3; k++) begin
            strobe(8'(na[k]), 8'(nd[k]));
            wait_idle($sformatf("bnd%0d", k));
            check_disp($sformatf("bnd_a%0d_d%0d", na[k], nd[k]), na[k], nd[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
